// File: rtl/dcm_prog_pkg.sv
// Shared types and constants for the DCM_CLKGEN PROG-port sequencer.
package dcm_prog_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_REJECT,
    S_LOADD,
    S_GAP1,
    S_LOADM,
    S_GAP2,
    S_GO,
    S_WAIT_LO,
    S_WAIT_HI,
    S_FIN
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_INVALID = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Command pairs are shifted out bit0 first, ahead of the value.
  localparam logic [1:0] CMD_LOADD = 2'b01;
  localparam logic [1:0] CMD_LOADM = 2'b11;

  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prog_shifter.sv
// Serialiser for one PROG command word: 2-bit command then a VALW-bit value, LSB first.
module prog_shifter
  import dcm_prog_pkg::*;
#(
  parameter int VALW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [1:0]      cmd,
  input  logic [VALW-1:0] val,
  output logic            bit_out,
  output logic            done
);

  localparam int CW = chw(VALW + 3);
  localparam logic [CW-1:0] LEN = CW'(VALW + 2);

  logic [VALW+1:0] sr;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LEN;
    end else if (shift && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sr <= {val, cmd};
    end else if (shift) begin
      sr <= sr >> 1;
    end
  end

  // bit_out is the bit the caller registers on the same edge that shifts it away.
  assign bit_out = sr[0];
  assign done    = (cnt == '0);

endmodule

// File: rtl/dcm_clkgen_prog.sv
// Multi-channel DCM_CLKGEN PROG sequencer: validates one (ch, M, D) request, streams
// LoadD / LoadM / GO onto the selected channel and waits for PROGDONE with a timeout.
module dcm_clkgen_prog
  import dcm_prog_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int VALW    = 8,
  parameter int TIMEOUT = 4096,
  localparam int CHW    = chw(NCH)
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [CHW-1:0]  req_ch,
  input  logic [VALW:0]   req_m,
  input  logic [VALW:0]   req_d,
  output logic [NCH-1:0]  prog_en,
  output logic [NCH-1:0]  prog_data,
  input  logic [NCH-1:0]  prog_done_i,
  output logic            busy,
  output logic            done_o,
  output logic [1:0]      err_o,
  output logic [CHW-1:0]  last_ch
);

  // M and D carry one extra bit so the top legal value 2^VALW is representable.
  localparam int TW = chw(TIMEOUT);
  localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT - 1);
  localparam logic [VALW:0]  VMAX  = {1'b1, {VALW{1'b0}}};
  localparam logic [CHW:0]   NCH_L = (CHW+1)'(NCH);

  state_t          state;
  logic [CHW-1:0]  ch;
  logic [VALW:0]   m_raw;
  logic [VALW:0]   d_raw;
  logic [TW-1:0]   tcnt;
  logic [NCH-1:0]  sel;
  logic            accept;
  logic            req_ok;
  logic            pd;
  logic            sh_load;
  logic            sh_shift;
  logic [1:0]      sh_cmd;
  logic [VALW-1:0] sh_val;
  logic            sh_bit;
  logic            sh_done;

  assign accept = (state == S_IDLE) && req_valid;
  assign sel    = NCH'(1) << ch;
  assign pd     = |(prog_done_i & sel);
  assign req_ok = (m_raw >= (VALW+1)'(2)) && (m_raw <= VMAX) &&
                  (d_raw != '0) && (d_raw <= VMAX) && ({1'b0, ch} < NCH_L);

  // D is loaded straight from the request on the accept edge; M once LoadD drains.
  assign sh_load  = accept || (state == S_LOADD && sh_done);
  assign sh_shift = (state == S_CHECK && req_ok) || state == S_GAP1 ||
                    state == S_LOADD || state == S_LOADM;
  assign sh_cmd   = (state == S_IDLE) ? CMD_LOADD : CMD_LOADM;
  assign sh_val   = (state == S_IDLE) ? VALW'(req_d - (VALW+1)'(1))
                                      : VALW'(m_raw - (VALW+1)'(1));

  prog_shifter #(.VALW(VALW)) u_shifter (
    .clk     (clk),
    .rst     (reset_i),
    .load    (sh_load),
    .shift   (sh_shift),
    .cmd     (sh_cmd),
    .val     (sh_val),
    .bit_out (sh_bit),
    .done    (sh_done)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      ch    <= req_ch;
      m_raw <= req_m;
      d_raw <= req_d;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      prog_en   <= '0;
      prog_data <= '0;
      busy      <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= ERR_OK;
      last_ch   <= '0;
      tcnt      <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          state     <= S_CHECK;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
        S_CHECK: if (req_ok) begin
          state     <= S_LOADD;
          prog_en   <= sel;
          prog_data <= sel & {NCH{sh_bit}};
        end else begin
          state <= S_REJECT;
        end
        S_REJECT: begin
          state   <= S_FIN;
          done_o  <= 1'b1;
          err_o   <= ERR_INVALID;
          busy    <= 1'b0;
          last_ch <= ch;
        end
        S_LOADD: if (sh_done) begin
          state     <= S_GAP1;
          prog_en   <= '0;
          prog_data <= '0;
        end else begin
          prog_data <= sel & {NCH{sh_bit}};
        end
        S_GAP1: begin
          state     <= S_LOADM;
          prog_en   <= sel;
          prog_data <= sel & {NCH{sh_bit}};
        end
        S_LOADM: if (sh_done) begin
          state     <= S_GAP2;
          prog_en   <= '0;
          prog_data <= '0;
        end else begin
          prog_data <= sel & {NCH{sh_bit}};
        end
        S_GAP2: begin
          state     <= S_GO;
          prog_en   <= sel;
          prog_data <= '0;
        end
        S_GO: begin
          state   <= S_WAIT_LO;
          prog_en <= '0;
          tcnt    <= '0;
        end
        // Timeout wins over a PROGDONE edge seen on the final counted cycle.
        S_WAIT_LO, S_WAIT_HI: begin
          if (tcnt == TMAX) begin
            state   <= S_FIN;
            done_o  <= 1'b1;
            err_o   <= ERR_TIMEOUT;
            busy    <= 1'b0;
            last_ch <= ch;
          end else if (state == S_WAIT_HI && pd) begin
            state   <= S_FIN;
            done_o  <= 1'b1;
            err_o   <= ERR_OK;
            busy    <= 1'b0;
            last_ch <= ch;
          end else begin
            if (state == S_WAIT_LO && !pd) state <= S_WAIT_HI;
            tcnt <= tcnt + TW'(1);
          end
        end
        S_FIN: begin
          state     <= S_IDLE;
          done_o    <= 1'b0;
          err_o     <= ERR_OK;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// Bench for dcm_clkgen_prog: cycle-indexed reference model plus directed literal checks.
module tb_dcm_clkgen_prog;

  localparam int NCH = 3;
  localparam int VALW = 8;
  localparam int TIMEOUT = 64;
  localparam int CHW = 2;
  localparam int BIG = 1 << 30;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [CHW-1:0]   req_ch = '0;
  logic [VALW:0]    req_m = '0;
  logic [VALW:0]    req_d = '0;
  logic [NCH-1:0]   prog_en;
  logic [NCH-1:0]   prog_data;
  logic [NCH-1:0]   prog_done_i = '1;
  logic             busy;
  logic             done_o;
  logic [1:0]       err_o;
  logic [CHW-1:0]   last_ch;

  dcm_clkgen_prog #(.NCH(NCH), .VALW(VALW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ch      (req_ch),
    .req_m       (req_m),
    .req_d       (req_d),
    .prog_en     (prog_en),
    .prog_data   (prog_data),
    .prog_done_i (prog_done_i),
    .busy        (busy),
    .done_o      (done_o),
    .err_o       (err_o),
    .last_ch     (last_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic           ready;
    logic           busy;
    logic           done;
    logic [1:0]     err;
    logic [NCH-1:0] en;
    logic [NCH-1:0] data;
    logic [CHW-1:0] lch;
  } obs_t;

  // Reference model: one request described by its accept cycle and derived timeline.
  bit              m_active = 1'b0;
  bit              m_valid = 1'b0;
  int              m_t0 = 0;
  int              m_done = 0;
  int              m_ch = 0;
  logic [1:0]      m_code = 2'd0;
  logic [VALW+1:0] m_dseq = '0;
  logic [VALW+1:0] m_mseq = '0;
  logic [CHW-1:0]  m_lch_prev = '0;

  // DCM PROGDONE model: stale high, low on [pd_drop, pd_rise), high again after.
  int pd_ch = 0;
  int pd_drop = BIG;
  int pd_rise = BIG;

  always @(negedge clk)
    for (int i = 0; i < NCH; i++)
      prog_done_i[i] <= !(i == pd_ch && cyc >= pd_drop && cyc < pd_rise);

  function automatic obs_t expect_at(input int c);
    obs_t e;
    int r;
    int go;
    e = '0;
    e.ready = 1'b1;
    e.lch = m_lch_prev;
    if (!m_active) return e;
    r = c - m_t0;
    if (r < 0) return e;
    if (r < m_done) begin
      e.ready = 1'b0;
      e.busy = 1'b1;
    end else begin
      e.lch = CHW'(m_ch);
      if (r == m_done) begin
        e.ready = 1'b0;
        e.done = 1'b1;
        e.err = m_code;
      end
    end
    go = 2 * (VALW + 2) + 3;
    if (m_valid) begin
      if (r >= 1 && r <= VALW + 2) begin
        e.en[m_ch] = 1'b1;
        e.data[m_ch] = m_dseq[r - 1];
      end else if (r >= VALW + 4 && r <= 2 * VALW + 5) begin
        e.en[m_ch] = 1'b1;
        e.data[m_ch] = m_mseq[r - (VALW + 4)];
      end else if (r == go) begin
        e.en[m_ch] = 1'b1;
      end
    end
    return e;
  endfunction

  obs_t g_obs;
  obs_t e_obs;

  always @(negedge clk) begin
    if (chk_en) begin
      g_obs.ready = req_ready;
      g_obs.busy  = busy;
      g_obs.done  = done_o;
      g_obs.err   = err_o;
      g_obs.en    = prog_en;
      g_obs.data  = prog_data;
      g_obs.lch   = last_ch;
      e_obs = expect_at(cyc);
      checks++;
      if (g_obs !== e_obs) begin
        errors++;
        $display("FAIL cycle %0d outputs got %h expected %h (ready,busy,done,err,en,data,lch)",
                 cyc, g_obs, e_obs);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic at_cycle(input int c);
    if (cyc > c) begin
      checks++;
      errors++;
      $display("FAIL at_cycle late got %0d expected %0d", cyc, c);
    end
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue(input int ch, input int m, input int d, input int drop_rel,
                       input int rise_rel);
    int l;
    int h;
    int lim;
    @(negedge clk);
    if (m_active) m_lch_prev = CHW'(m_ch);
    m_active = 1'b1;
    m_t0 = cyc + 1;
    m_ch = ch;
    m_valid = (m >= 2) && (m <= (1 << VALW)) && (d >= 1) && (d <= (1 << VALW)) && (ch < NCH);
    m_dseq = {VALW'(d - 1), 2'b01};
    m_mseq = {VALW'(m - 1), 2'b11};
    if (!m_valid) begin
      m_done = 2;
      m_code = 2'd1;
    end else begin
      l = (drop_rel > 24) ? drop_rel : 24;
      h = (rise_rel > l + 1) ? rise_rel : l + 1;
      lim = 24 + TIMEOUT - 1;
      if (l >= lim || h >= lim) begin
        m_done = 24 + TIMEOUT;
        m_code = 2'd2;
      end else begin
        m_done = h + 1;
        m_code = 2'd0;
      end
    end
    pd_ch = ch;
    pd_drop = (drop_rel >= BIG) ? BIG : m_t0 + drop_rel;
    pd_rise = (rise_rel >= BIG) ? BIG : m_t0 + rise_rel;
    req_ch = CHW'(ch);
    req_m = (VALW+1)'(m);
    req_d = (VALW+1)'(d);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  logic [9:0] gd;
  logic [9:0] gm;
  int inv_ch[3] = '{0, 0, 3};
  int inv_m[3]  = '{1, 5, 5};
  int inv_d[3]  = '{4, 0, 2};

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_en", 32'(prog_en), 32'h0);
    check("rst_data", 32'(prog_data), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_last_ch", 32'(last_ch), 32'h0);
    reset_i = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // ch1, M=5, D=2 with PROGDONE low 26..39
    issue(1, 5, 2, 26, 40);
    for (int k = 1; k <= 10; k++) begin
      at_cycle(m_t0 + k);
      gd[k - 1] = prog_data[1];
    end
    check("loadd_bits", 32'(gd), 32'h005);
    for (int k = 12; k <= 21; k++) begin
      at_cycle(m_t0 + k);
      gm[k - 12] = prog_data[1];
    end
    check("loadm_bits", 32'(gm), 32'h013);
    at_cycle(m_t0 + 23);
    check("go_en", 32'(prog_en), 32'h2);
    check("go_data", 32'(prog_data), 32'h0);
    at_cycle(m_t0 + 40);
    check("done_early", 32'(done_o), 32'h0);
    at_cycle(m_t0 + 41);
    check("done_pulse", 32'(done_o), 32'h1);
    check("done_err", 32'(err_o), 32'h0);
    check("done_last_ch", 32'(last_ch), 32'h1);
    at_cycle(m_t0 + 42);
    check("ready_back", 32'(req_ready), 32'h1);

    // rejected requests: M<2, D=0, channel out of range
    for (int i = 0; i < 3; i++) begin
      issue(inv_ch[i], inv_m[i], inv_d[i], BIG, BIG);
      at_cycle(m_t0 + 1);
      check("inv_busy", 32'(busy), 32'h1);
      at_cycle(m_t0 + 2);
      check("inv_done", 32'(done_o), 32'h1);
      check("inv_err", 32'(err_o), 32'h1);
      at_cycle(m_t0 + 3);
      check("inv_ready", 32'(req_ready), 32'h1);
    end

    // PROGDONE stuck high -> timeout
    issue(0, 3, 3, BIG, BIG);
    at_cycle(m_t0 + 87);
    check("to_pending", 32'(done_o), 32'h0);
    at_cycle(m_t0 + 88);
    check("to_done", 32'(done_o), 32'h1);
    check("to_err", 32'(err_o), 32'h2);
    check("to_busy", 32'(busy), 32'h0);
    at_cycle(m_t0 + 90);

    // second request during LOADM is ignored
    issue(1, 5, 2, 30, 35);
    at_cycle(m_t0 + 13);
    req_ch = 2'd0;
    req_m = 9'd7;
    req_d = 9'd7;
    req_valid = 1'b1;
    at_cycle(m_t0 + 16);
    check("ign_ready", 32'(req_ready), 32'h0);
    req_valid = 1'b0;
    at_cycle(m_t0 + 36);
    check("ign_done", 32'(done_o), 32'h1);
    check("ign_last_ch", 32'(last_ch), 32'h1);
    at_cycle(m_t0 + 38);

    // async reset mid-LOADM
    issue(1, 4, 3, BIG, BIG);
    at_cycle(m_t0 + 14);
    check("pre_rst_en", 32'(prog_en), 32'h2);
    @(posedge clk);
    #2;
    reset_i = 1'b1;
    m_active = 1'b0;
    m_lch_prev = '0;
    pd_drop = BIG;
    #1;
    check("arst_en", 32'(prog_en), 32'h0);
    check("arst_ready", 32'(req_ready), 32'h1);
    check("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    #2;
    reset_i = 1'b0;
    at_cycle(cyc + 10);

    // full-range M=256, D=256 on ch0
    issue(0, 256, 256, 24, 30);
    for (int k = 1; k <= 10; k++) begin
      at_cycle(m_t0 + k);
      gd[k - 1] = prog_data[0];
    end
    check("max_loadd_bits", 32'(gd), 32'h3FD);
    for (int k = 12; k <= 21; k++) begin
      at_cycle(m_t0 + k);
      gm[k - 12] = prog_data[0];
    end
    check("max_loadm_bits", 32'(gm), 32'h3FF);
    at_cycle(m_t0 + 31);
    check("max_done", 32'(done_o), 32'h1);
    check("max_err", 32'(err_o), 32'h0);
    at_cycle(m_t0 + 34);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
